// File: rtl/hb_lup_req_gen_if.sv
// Request-side bus bundle for the hash-table lookup generator: lookup and
// update sources plus the packed request stream toward the hash-table core.
interface hb_lup_req_gen_if;
  localparam int unsigned KEY_W  = 64;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned REQ_W  = 96;

  logic              s_lup_valid;
  logic [KEY_W-1:0]  s_lup_key;
  logic              s_lup_ready;

  logic              s_upd_valid;
  logic              s_upd_op;
  logic [KEY_W-1:0]  s_upd_key;
  logic [ADDR_W-1:0] s_upd_addr;
  logic              s_upd_ready;

  logic              m_axis_lup_req_valid;
  logic [REQ_W-1:0]  m_axis_lup_req_data;
  logic              m_axis_lup_req_ready;

  modport slave (
    input  s_lup_valid, s_lup_key,
    output s_lup_ready,
    input  s_upd_valid, s_upd_op, s_upd_key, s_upd_addr,
    output s_upd_ready,
    output m_axis_lup_req_valid, m_axis_lup_req_data,
    input  m_axis_lup_req_ready
  );

  modport master (
    output s_lup_valid, s_lup_key,
    input  s_lup_ready,
    output s_upd_valid, s_upd_op, s_upd_key, s_upd_addr,
    input  s_upd_ready,
    input  m_axis_lup_req_valid, m_axis_lup_req_data,
    output m_axis_lup_req_ready
  );
endinterface

// File: rtl/hb_lup_req_gen.sv
// Arbitrates lookup keys and table updates into a single registered request
// stream, limiting in-flight lookups with a credit counter.
module hb_lup_req_gen #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  hb_lup_req_gen_if.slave   bus,
  input  logic              rsp_fire,
  output logic [CNT_W-1:0]  outstanding,
  output logic [31:0]       stat_lup_cnt,
  output logic [31:0]       stat_upd_cnt
);
  localparam int unsigned PAD_W  = 14;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned REQ_W  = 96;
  localparam int unsigned STAT_W = 32;

  localparam logic [1:0] OP_LUP = 2'b00;
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;

  logic              req_valid_q, req_valid_d;
  logic [REQ_W-1:0]  req_data_q,  req_data_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [STAT_W-1:0] stat_lup_q, stat_lup_d;
  logic [STAT_W-1:0] stat_upd_q, stat_upd_d;
  logic              last_lup_q, last_lup_d;

  logic slot_free_c, lup_elig_c, upd_elig_c, grant_lup_c, grant_upd_c, credit_ret_c;

  // Arbitration: last_lup_q=1 means the lookup side won last, so updates go first on a tie.
  always_comb begin
    slot_free_c  = !req_valid_q | bus.m_axis_lup_req_ready;
    lup_elig_c   = bus.s_lup_valid & (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    upd_elig_c   = bus.s_upd_valid;
    grant_lup_c  = slot_free_c & lup_elig_c & (!upd_elig_c | !last_lup_q);
    grant_upd_c  = slot_free_c & upd_elig_c & (!lup_elig_c |  last_lup_q);
    credit_ret_c = rsp_fire & (outstanding_q != '0);
  end

  assign bus.s_lup_ready          = grant_lup_c;
  assign bus.s_upd_ready          = grant_upd_c;
  assign bus.m_axis_lup_req_valid = req_valid_q;
  assign bus.m_axis_lup_req_data  = req_data_q;
  assign outstanding              = outstanding_q;
  assign stat_lup_cnt             = stat_lup_q;
  assign stat_upd_cnt             = stat_upd_q;

  always_comb begin
    req_valid_d   = req_valid_q;
    req_data_d    = req_data_q;
    last_lup_d    = last_lup_q;
    stat_lup_d    = stat_lup_q;
    stat_upd_d    = stat_upd_q;
    outstanding_d = outstanding_q;

    if (grant_lup_c) begin
      req_valid_d = 1'b1;
      req_data_d  = {PAD_W'(0), OP_LUP, ADDR_W'(0), bus.s_lup_key};
      last_lup_d  = 1'b1;
      stat_lup_d  = stat_lup_q + STAT_W'(1);
    end else if (grant_upd_c) begin
      req_valid_d = 1'b1;
      req_data_d  = bus.s_upd_op ? {PAD_W'(0), OP_DEL, ADDR_W'(0), bus.s_upd_key}
                                 : {PAD_W'(0), OP_INS, bus.s_upd_addr, bus.s_upd_key};
      last_lup_d  = 1'b0;
      stat_upd_d  = stat_upd_q + STAT_W'(1);
    end else if (bus.m_axis_lup_req_ready) begin
      req_valid_d = 1'b0;
    end

    // A credit returned this cycle is only usable by the next cycle's arbitration.
    case ({grant_lup_c, credit_ret_c})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid_q   <= 1'b0;
      req_data_q    <= '0;
      outstanding_q <= '0;
      stat_lup_q    <= '0;
      stat_upd_q    <= '0;
      last_lup_q    <= 1'b0;
    end else begin
      req_valid_q   <= req_valid_d;
      req_data_q    <= req_data_d;
      outstanding_q <= outstanding_d;
      stat_lup_q    <= stat_lup_d;
      stat_upd_q    <= stat_upd_d;
      last_lup_q    <= last_lup_d;
    end
  end
endmodule

// File: tb/tb_hb_lup_req_gen.sv
// Directed plus randomized bench for hb_lup_req_gen against a transaction-level
// reference model of arbitration, credits and the packed request word.
module tb_hb_lup_req_gen;
  localparam int unsigned MAX = 8;
  localparam int unsigned CW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rsp_fire;
  logic [CW-1:0] outstanding;
  logic [31:0] stat_lup_cnt, stat_upd_cnt;

  always #5 clk = ~clk;

  hb_lup_req_gen_if bus();

  hb_lup_req_gen #(.MAX_OUTSTANDING(MAX), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .rsp_fire     (rsp_fire),
    .outstanding  (outstanding),
    .stat_lup_cnt (stat_lup_cnt),
    .stat_upd_cnt (stat_upd_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          e_valid;
  logic [95:0] e_data;
  int          e_out;
  bit          e_last_lup;
  logic [31:0] e_lup, e_upd;
  logic [1:0]  obs_ops[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] word(input logic [1:0] op, input logic [15:0] addr,
                                       input logic [63:0] key);
    logic [13:0] pad = '0;
    return {pad, op, addr, key};
  endfunction

  function automatic void model_reset();
    e_valid = 1'b0; e_data = '0; e_out = 0; e_last_lup = 1'b0; e_lup = '0; e_upd = '0;
  endfunction

  // One clock: check at negedge against the model, advance the model, return after posedge.
  task automatic cycle();
    bit slot, le, ue, gl, gu;
    int old_out;
    @(negedge clk);
    slot = !e_valid || bus.m_axis_lup_req_ready;
    le   = bus.s_lup_valid && (e_out < int'(MAX));
    ue   = bus.s_upd_valid;
    gl   = slot && le && (!ue || !e_last_lup);
    gu   = slot && ue && (!le || e_last_lup);
    chk("lup_ready", 96'(bus.s_lup_ready), 96'(gl));
    chk("upd_ready", 96'(bus.s_upd_ready), 96'(gu));
    chk("m_valid", 96'(bus.m_axis_lup_req_valid), 96'(e_valid));
    if (e_valid) chk("m_data", bus.m_axis_lup_req_data, e_data);
    chk("outstanding", 96'(outstanding), 96'(e_out));
    chk("stat_lup", 96'(stat_lup_cnt), 96'(e_lup));
    chk("stat_upd", 96'(stat_upd_cnt), 96'(e_upd));
    if (bus.m_axis_lup_req_valid && bus.m_axis_lup_req_ready)
      obs_ops.push_back(bus.m_axis_lup_req_data[81:80]);
    old_out = e_out;
    if (!rst_n) model_reset();
    else begin
      if (gl) begin
        e_valid = 1'b1; e_data = word(2'b00, 16'h0, bus.s_lup_key);
        e_lup++; e_last_lup = 1'b1; e_out++;
      end else if (gu) begin
        e_valid = 1'b1;
        e_data  = bus.s_upd_op ? word(2'b10, 16'h0, bus.s_upd_key)
                               : word(2'b01, bus.s_upd_addr, bus.s_upd_key);
        e_upd++; e_last_lup = 1'b0;
      end else if (bus.m_axis_lup_req_ready) e_valid = 1'b0;
      if (rsp_fire && old_out > 0) e_out--;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] k;
    rst_n = 1'b0; rsp_fire = 1'b0;
    bus.s_lup_valid = 1'b0; bus.s_lup_key = '0;
    bus.s_upd_valid = 1'b0; bus.s_upd_op = 1'b0; bus.s_upd_key = '0; bus.s_upd_addr = '0;
    bus.m_axis_lup_req_ready = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cycle();
    chk("rst_valid", 96'(bus.m_axis_lup_req_valid), 96'(0));
    chk("rst_data", bus.m_axis_lup_req_data, 96'(0));
    chk("rst_out", 96'(outstanding), 96'(0));
    chk("rst_stats", 96'({stat_lup_cnt, stat_upd_cnt}), 96'(0));
    rst_n = 1'b1;
    cycle();

    // Single lookup
    bus.s_lup_valid = 1'b1; bus.s_lup_key = 64'h1122334455667788;
    cycle();
    bus.s_lup_valid = 1'b0;
    chk("t1_valid", 96'(bus.m_axis_lup_req_valid), 96'(1));
    chk("t1_data", bus.m_axis_lup_req_data, word(2'b00, 16'h0, 64'h1122334455667788));
    chk("t1_out", 96'(outstanding), 96'(1));
    chk("t1_stat", 96'(stat_lup_cnt), 96'(1));
    rsp_fire = 1'b1; cycle(); rsp_fire = 1'b0;
    cycle();

    // Insert held by back-pressure, with a delete queued behind it
    bus.m_axis_lup_req_ready = 1'b0;
    bus.s_upd_valid = 1'b1; bus.s_upd_op = 1'b0; bus.s_upd_key = 64'hA; bus.s_upd_addr = 16'h0042;
    cycle();
    bus.s_upd_op = 1'b1; bus.s_upd_key = 64'hB; bus.s_upd_addr = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_data", bus.m_axis_lup_req_data, word(2'b01, 16'h0042, 64'hA));
      chk("t2_hold_rdy", 96'(bus.s_upd_ready), 96'(0));
      cycle();
    end
    bus.m_axis_lup_req_ready = 1'b1;
    cycle();
    bus.s_upd_valid = 1'b0;
    chk("t2_next", bus.m_axis_lup_req_data, word(2'b10, 16'h0, 64'hB));
    cycle();

    // Both sources continuously valid: ops must alternate
    obs_ops.delete();
    bus.s_lup_valid = 1'b1; bus.s_upd_valid = 1'b1; bus.s_upd_op = 1'b0; rsp_fire = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.s_lup_key = {$urandom, $urandom}; bus.s_upd_key = {$urandom, $urandom};
      cycle();
    end
    bus.s_lup_valid = 1'b0; bus.s_upd_valid = 1'b0;
    cycle();
    chk("t3_count", 96'(obs_ops.size() >= 10), 96'(1));
    for (int i = 1; i < obs_ops.size(); i++)
      chk("t3_alternate", 96'(obs_ops[i] == 2'b00), 96'(obs_ops[i-1] != 2'b00));
    for (int i = 0; i < 20 && e_out > 0; i++) cycle();
    rsp_fire = 1'b0;
    chk("t3_drained", 96'(outstanding), 96'(0));

    // Credit exhaustion
    bus.s_lup_valid = 1'b1;
    for (int i = 0; i < int'(MAX); i++) begin
      bus.s_lup_key = {$urandom, $urandom}; cycle();
    end
    chk("t4_out_full", 96'(outstanding), 96'(MAX));
    chk("t4_stall", 96'(bus.s_lup_ready), 96'(0));
    bus.s_upd_valid = 1'b1; bus.s_upd_op = 1'b0; bus.s_upd_key = 64'h55; bus.s_upd_addr = 16'h1234;
    cycle();
    bus.s_upd_valid = 1'b0;
    chk("t4_upd_flows", bus.m_axis_lup_req_data, word(2'b01, 16'h1234, 64'h55));
    rsp_fire = 1'b1;
    chk("t4_rsp_same_cyc", 96'(bus.s_lup_ready), 96'(0));
    cycle();
    rsp_fire = 1'b0;
    chk("t4_credit_back", 96'(bus.s_lup_ready), 96'(1));
    k = 64'hCAFE0000BEEF0001; bus.s_lup_key = k;
    cycle();
    chk("t4_one_more", bus.m_axis_lup_req_data, word(2'b00, 16'h0, k));
    chk("t4_full_again", 96'(outstanding), 96'(MAX));
    chk("t4_stall_again", 96'(bus.s_lup_ready), 96'(0));

    // Simultaneous accept and response; response at zero
    bus.s_lup_valid = 1'b0; rsp_fire = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("t5_out3", 96'(outstanding), 96'(3));
    bus.s_lup_valid = 1'b1;
    cycle();
    bus.s_lup_valid = 1'b0;
    chk("t5_same_cyc", 96'(outstanding), 96'(3));
    for (int i = 0; i < 3; i++) cycle();
    cycle();
    rsp_fire = 1'b0;
    chk("t5_sat_zero", 96'(outstanding), 96'(0));

    // Reset mid-transfer
    bus.s_lup_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_lup_key = {$urandom, $urandom}; cycle();
    end
    bus.s_lup_valid = 1'b0; bus.m_axis_lup_req_ready = 1'b0;
    cycle();
    chk("t6_pre_valid", 96'(bus.m_axis_lup_req_valid), 96'(1));
    chk("t6_pre_out", 96'(outstanding), 96'(5));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_valid", 96'(bus.m_axis_lup_req_valid), 96'(0));
    chk("t6_out", 96'(outstanding), 96'(0));
    chk("t6_stats", 96'({stat_lup_cnt, stat_upd_cnt}), 96'(0));

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst_n                    = ($urandom_range(0, 299) != 0);
      bus.s_lup_valid          = ($urandom_range(0, 3) != 0);
      bus.s_lup_key            = {$urandom, $urandom};
      bus.s_upd_valid          = ($urandom_range(0, 2) == 0);
      bus.s_upd_op             = 1'($urandom_range(0, 1));
      bus.s_upd_key            = {$urandom, $urandom};
      bus.s_upd_addr           = 16'($urandom);
      bus.m_axis_lup_req_ready = ($urandom_range(0, 3) != 0);
      rsp_fire                 = ($urandom_range(0, 1) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
